// File: rtl/conbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conbus_pkg
// Purpose  : Shared constants, FSM state encoding and helpers for the
//            five-master shared-slave Wishbone bus (conbus_share5).
// Revision : 1.0 - initial release
// ============================================================================
package conbus_pkg;

  localparam int NUM_M = 5;  // number of masters sharing the slave
  localparam int GNT_W = 3;  // width of the arbiter grant index

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // One-hot decode of a grant index; indices beyond the master count yield 0.
  function automatic logic [NUM_M-1:0] onehot(input logic [GNT_W-1:0] idx);
    onehot = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (idx == GNT_W'(k)) onehot[k] = 1'b1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/conbus_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module   : conbus_tmo_cnt
// Purpose  : Slave wait counter for the shared bus. Counts stalled wait
//            cycles and flags the cycle in which the next increment would
//            reach TIMEOUT-1, so the owner can abort on that edge.
// Revision : 1.0 - initial release
// ============================================================================
module conbus_tmo_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic last
);

  localparam int                 CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   LAST_VAL = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt;

  // Count stalled wait cycles; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != LAST_VAL) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule
`default_nettype wire

// File: rtl/conbus_share5.sv
`default_nettype none
// ============================================================================
// Module   : conbus_share5
// Purpose  : Connects five Wishbone masters to one shared slave according to
//            an external grant index. Request and ack paths are purely
//            combinational. With CONBUS_TIMEOUT_EN defined, a stalled slave
//            is aborted after TIMEOUT wait cycles with a one-cycle m_err.
// Revision : 1.0 - initial release
// ============================================================================
module conbus_share5
  import conbus_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int DW      = 32
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_M*32-1:0]       m_adr,
  input  logic [NUM_M*DW-1:0]       m_dat_w,
  input  logic [NUM_M*(DW/8)-1:0]   m_sel,
  input  logic [NUM_M-1:0]          m_we,
  input  logic [NUM_M-1:0]          m_cyc,
  input  logic [NUM_M-1:0]          m_stb,
  output logic [DW-1:0]             m_dat_r,
  output logic [NUM_M-1:0]          m_ack,
  output logic [NUM_M-1:0]          m_err,
  output logic [NUM_M-1:0]          req,
  input  logic [GNT_W-1:0]          gnt,
  output logic [31:0]               s_adr,
  output logic [DW-1:0]             s_dat_w,
  output logic [DW/8-1:0]           s_sel,
  output logic                      s_we,
  output logic                      s_cyc,
  output logic                      s_stb,
  input  logic [DW-1:0]             s_dat_r,
  input  logic                      s_ack,
  output logic                      tmo_flag,
  output logic [GNT_W-1:0]          tmo_master
);

  localparam int SW = DW / 8;

  logic cyc_g;     // m_cyc of the granted master (0 when no master granted)
  logic stb_g;     // m_stb of the granted master
  logic aborting;  // bus is in its one-cycle abort window

  // Select the granted master's request; a grant beyond the last master selects nothing.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    cyc_g   = 1'b0;
    stb_g   = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt == GNT_W'(k)) begin
        s_adr   = m_adr[32*k +: 32];
        s_dat_w = m_dat_w[DW*k +: DW];
        s_sel   = m_sel[SW*k +: SW];
        s_we    = m_we[k];
        cyc_g   = m_cyc[k];
        stb_g   = m_stb[k];
      end
    end
  end

  assign req     = m_cyc;
  assign m_dat_r = s_dat_r;
  assign s_cyc   = cyc_g & ~aborting;
  assign s_stb   = stb_g & ~aborting;
  assign m_ack   = onehot(gnt) & {NUM_M{s_ack & cyc_g & stb_g & ~aborting}};

`ifdef CONBUS_TIMEOUT_EN
  state_t           state;
  logic [GNT_W-1:0] gnt_q;      // grant seen in the previous cycle
  logic             wait_exit;  // stalled transfer ended normally
  logic             last;       // next stalled cycle reaches TIMEOUT-1
  logic             cnt_clr;

  assign aborting  = (state == ST_ABORT);
  assign wait_exit = s_ack | (gnt != gnt_q) | ~stb_g;
  // Hold the counter at zero outside WAIT, on any exit and when aborting.
  assign cnt_clr   = (state != ST_WAIT) | wait_exit | last;

  conbus_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (cnt_clr),
    .last  (last)
  );

  // Track stalled transfers and raise a one-cycle error when the slave hangs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      m_err      <= '0;
      tmo_flag   <= 1'b0;
      tmo_master <= '0;
    end else begin
      gnt_q <= gnt;
      m_err <= '0;
      case (state)
        ST_IDLE: begin
          if (s_cyc & s_stb & ~s_ack) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A coincident ack wins over the timeout.
          if (wait_exit) begin
            state <= ST_IDLE;
          end else if (last) begin
            state      <= ST_ABORT;
            m_err      <= onehot(gnt);
            tmo_flag   <= 1'b1;
            tmo_master <= gnt;
          end
        end
        ST_ABORT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  logic unused_ok;

  assign aborting   = 1'b0;
  assign m_err      = '0;
  assign tmo_flag   = 1'b0;
  assign tmo_master = '0;
  // Clock, reset and TIMEOUT have no consumer when the timeout logic is absent.
  assign unused_ok  = ^{sys_clk, sys_rst_n, (TIMEOUT > 1)};
`endif

endmodule
`default_nettype wire

// File: doc/conbus_share5.md
CONBUS_SHARE5 -- requirements
Module: conbus_share5

Interface
Parameters:
REQ-001 SHALL provide parameter `TIMEOUT`, default 1024: slave wait cycles before abort; legal range 2..65535.
REQ-002 SHALL provide parameter `DW`, default 32: data width, in bits.

Ports:
REQ-003 SHALL provide port `sys_clk`  in  1  system clock; all state is rising-edge.
REQ-004 SHALL provide port `sys_rst_n`  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port `m_adr`  in  5x32  master addresses; master k occupies bits [32k+31:32k].
REQ-006 SHALL provide port `m_dat_w`  in  5xDW  master write data, packed the same way.
REQ-007 SHALL provide port `m_sel`  in  5x(DW/8)  master byte selects.
REQ-008 SHALL provide ports `m_we`, `m_cyc`, `m_stb`  in  5  per-master Wishbone controls.
REQ-009 SHALL provide port `m_dat_r`  out  DW  slave read data, broadcast to all masters.
REQ-010 SHALL provide ports `m_ack`, `m_err`  out  5  per-master termination.
REQ-011 SHALL provide port `req`  out  5  arbitration request, equal to `m_cyc`.
REQ-012 SHALL provide port `gnt`  in  3  granted master index 0..4 from the arbiter; values 5..7 select no master.
REQ-013 SHALL provide ports `s_adr`, `s_dat_w`, `s_sel`, `s_we`, `s_cyc`, `s_stb`  out  shared-slave request.
REQ-014 SHALL provide ports `s_dat_r`  in  DW  and `s_ack`  in  1  shared-slave response.
REQ-015 SHALL provide ports `tmo_flag`  out  1  (sticky timeout seen) and `tmo_master`  out  3  (index of last aborted master).

Function
REQ-016 SHALL drive `s_adr`, `s_dat_w`, `s_sel` and `s_we` combinationally from master `gnt`.
REQ-017 SHALL drive `s_cyc` and `s_stb` as master `gnt` values, gated low during ABORT; 0 when `gnt` > 4.
REQ-018 SHALL drive `m_ack[gnt]` = `s_ack & m_cyc[gnt] & m_stb[gnt]`; all other `m_ack` bits SHALL be 0.
REQ-019 SHALL route `s_dat_r` to `m_dat_r` unconditionally, with zero latency.
REQ-020 SHALL implement a state machine with states IDLE, WAIT and ABORT.
- IDLE -> WAIT when `s_cyc & s_stb & ~s_ack`.
- WAIT -> IDLE on `s_ack`, or on `gnt` change, or on `~m_stb[gnt]`.
- WAIT -> ABORT when the wait counter reaches `TIMEOUT`-1 without `s_ack`.
- ABORT -> IDLE unconditionally after 1 cycle.
REQ-021 SHALL clear the wait counter in IDLE and on entry to ABORT, and SHALL increment it by 1 per WAIT cycle without `s_ack`; counter width SHALL be `$clog2(TIMEOUT)`, with no wrap.
REQ-022 SHALL, in ABORT, pulse `m_err[gnt]` high for exactly 1 cycle, force `s_cyc`/`s_stb` to 0, and force `m_ack` to 0.
REQ-023 SHALL, on entry to ABORT, set `tmo_flag`=1 and load `tmo_master`=`gnt`; `tmo_flag` SHALL clear only on reset.
REQ-024 SHALL give `s_ack` priority over timeout when `s_ack` coincides with the counter reaching `TIMEOUT`-1: ack passed through, no abort.
REQ-025 SHALL produce a transaction latency of 0 cycles request-to-slave and 0 cycles ack-to-master.

Reset
REQ-026 SHALL, while `sys_rst_n`=0, hold state=IDLE, counter=0, `tmo_flag`=0, `tmo_master`=0 and `m_err`=0.
REQ-027 SHALL, during reset, drive the combinational outputs from the current inputs; `s_cyc` then reflects `m_cyc[gnt]`.
REQ-028 SHALL, on reset assertion mid-WAIT, abandon the pending abort; no `m_err` pulse follows reset release.

Configuration
REQ-029 SHALL compile the timeout logic (counter, WAIT/ABORT, `m_err`, `tmo_flag`, `tmo_master`) only when `CONBUS_TIMEOUT_EN` is defined.
REQ-030 SHALL, without `CONBUS_TIMEOUT_EN`, tie `m_err`=0, `tmo_flag`=0 and `tmo_master`=0, and instantiate no counter flops; a hung slave then stalls the bus indefinitely.

Structure
REQ-031 SHALL place the master count (5), the grant index width (3) and the state encoding in the shared package `conbus_pkg`.
REQ-032 SHALL implement the wait counter and its compare as sub-module `conbus_tmo_cnt`, instantiated only under `CONBUS_TIMEOUT_EN`.

Verification
REQ-033 SHALL cover scenario: gnt=2, master 2 writes adr=0x40000010, dat=0xDEADBEEF; slave acks after 3 cycles -> s_adr/s_dat_w match, m_ack=5'b00100 for 1 cycle, m_err=0.
REQ-034 SHALL cover scenario: gnt=0, m_cyc=5'b00011 -> req=5'b00011; m_ack[1] never asserts while gnt=0.
REQ-035 SHALL cover scenario (TIMEOUT=8, macro on): gnt=3, slave never acks -> m_err=5'b01000 exactly 8 cycles after stb, s_stb=0 that cycle, tmo_flag=1, tmo_master=3.
REQ-036 SHALL cover scenario (TIMEOUT=8): s_ack arrives on wait cycle 7 -> ack delivered, no m_err, tmo_flag stays 0.
REQ-037 SHALL cover scenario: sys_rst_n pulsed low on wait cycle 5 of a hung transfer -> counter=0, tmo_flag=0, no m_err after release.
REQ-038 SHALL cover scenario (macro off): slave hung for 10000 cycles -> m_err stays 0, s_cyc stays 1.
